adpcm_enc_ctrl: RTL and testbench

ADPCM_ENC_CTRL -- requirements
Module: adpcm_enc_ctrl

---
 rtl/adpcm_enc_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_adpcm_enc_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_enc_ctrl.sv
// ---------------------------------------------------------------------------
// adpcm_enc_ctrl
//
// Sequencer that feeds 16-bit PCM samples one at a time to an external ADPCM
// codec core (encode direction), collects the 4-bit code for each sample and
// packs two codes per output byte. The first sample of a pair goes in the
// low nibble. A lone pending nibble can be pushed out early with flush.
//
// Core handshake: a sample is started by toggling core_req. The core drops
// core_ack while it works and raises it again when the code is ready. Each
// of the two waits has a timeout. If a timeout expires, the block parks in
// ERR with a sticky err_timeout flag until enable is dropped or rstn is
// asserted.
//
// Ports
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   enable       in   synchronous run enable (0 = clear and hold idle)
//   pcm_valid    in   PCM sample offered
//   pcm_ready    out  PCM sample accepted this cycle (high only in IDLE)
//   pcm[15:0]    in   signed PCM sample
//   byte_valid   out  packed ADPCM byte available (high only in OUT)
//   byte_ready   in   downstream accepts byte_out
//   byte_out[7:0]out  packed ADPCM byte {second code, first code}
//   flush        in   level request to emit a pending lone nibble
//   core_req     out  toggle-per-sample request to the codec core
//   core_ack     in   core idle indication (low while converting)
//   core_pcm     out  sample presented to the core
//   core_adpcm   in   4-bit code returned by the core
//   core_sel_rx  out  core direction select, tied to encode (0)
//   busy         out  high whenever the sequencer is not idle
//   err_timeout  out  sticky core-handshake timeout flag
//   sample_cnt   out  number of samples encoded (wraps at 16 bits)
// ---------------------------------------------------------------------------
module adpcm_enc_ctrl (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               pcm_valid,
  output logic               pcm_ready,
  input  logic signed [15:0] pcm,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [7:0]         byte_out,
  input  logic               flush,
  output logic               core_req,
  input  logic               core_ack,
  output logic [15:0]        core_pcm,
  input  logic [3:0]         core_adpcm,
  output logic               core_sel_rx,
  output logic               busy,
  output logic               err_timeout,
  output logic [15:0]        sample_cnt
);

  // Timer value at which the next unexpected ack sample ends in ERR:
  // the 4th consecutive "still idle" sample while waiting for the core to
  // start, or the 16th consecutive "still busy" sample while it converts.
  localparam logic [3:0] BUSY_LAST = 4'd3;
  localparam logic [3:0] DONE_LAST = 4'd15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    STORE     = 3'd4,
    OUT       = 3'd5,
    ERR       = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        core_req_q, core_req_d;
  logic [15:0] core_pcm_q, core_pcm_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic [3:0]  nib_lo_q, nib_lo_d;
  logic        half_q, half_d;
  logic [3:0]  timer_q, timer_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic        err_q, err_d;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      core_req_q   <= 1'b0;
      core_pcm_q   <= '0;
      byte_out_q   <= '0;
      nib_lo_q     <= '0;
      half_q       <= 1'b0;
      timer_q      <= '0;
      sample_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_req_q   <= core_req_d;
      core_pcm_q   <= core_pcm_d;
      byte_out_q   <= byte_out_d;
      nib_lo_q     <= nib_lo_d;
      half_q       <= half_d;
      timer_q      <= timer_d;
      sample_cnt_q <= sample_cnt_d;
      err_q        <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    core_req_d   = core_req_q;
    core_pcm_d   = core_pcm_q;
    byte_out_d   = byte_out_q;
    nib_lo_d     = nib_lo_q;
    half_d       = half_q;
    timer_d      = timer_q;
    sample_cnt_d = sample_cnt_q;
    err_d        = err_q;

    if (!enable) begin
      // Drop everything, including any half-packed byte. core_req keeps its
      // level: changing it here would look like a new request to the core.
      state_d      = IDLE;
      core_pcm_d   = '0;
      byte_out_d   = '0;
      nib_lo_d     = '0;
      half_d       = 1'b0;
      timer_d      = '0;
      sample_cnt_d = '0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // pcm_ready is high throughout IDLE, so pcm_valid alone is the
          // handshake. A new sample wins over flush.
          if (pcm_valid) begin
            core_pcm_d = pcm;
            state_d    = LAUNCH;
          end else if (flush && half_q) begin
            byte_out_d = {4'b0000, nib_lo_q};
            half_d     = 1'b0;
            state_d    = OUT;
          end
        end

        LAUNCH: begin
          core_req_d = ~core_req_q;
          timer_d    = '0;
          state_d    = WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (!core_ack) begin
            timer_d = '0;
            state_d = WAIT_DONE;
          end else if (timer_q == BUSY_LAST) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end

        WAIT_DONE: begin
          if (core_ack) begin
            state_d = STORE;
          end else if (timer_q == DONE_LAST) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end

        STORE: begin
          sample_cnt_d = sample_cnt_q + 16'd1;
          if (half_q) begin
            byte_out_d = {core_adpcm, nib_lo_q};
            half_d     = 1'b0;
            state_d    = OUT;
          end else begin
            nib_lo_d = core_adpcm;
            half_d   = 1'b1;
            state_d  = IDLE;
          end
        end

        OUT: begin
          // byte_out is only written on the way into OUT, so it stays put
          // for as long as the consumer stalls.
          if (byte_ready) begin
            state_d = IDLE;
          end
        end

        ERR: begin
          err_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pcm_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign byte_valid  = (state_q == OUT);
  assign byte_out    = byte_out_q;
  assign core_req    = core_req_q;
  assign core_pcm    = core_pcm_q;
  assign core_sel_rx = 1'b0;
  assign err_timeout = err_q;
  assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_adpcm_enc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adpcm_enc_ctrl
//
// Directed bench for adpcm_enc_ctrl. A small behavioural core answers each
// core_req toggle: ack falls on the next clock, stays low 7 clocks, then
// rises. The code it returns is core_pcm[11:8], so sample 0x0N00 encodes
// to nibble N. Mode 1 never drops ack; mode 2 drops ack and never raises it.
// ---------------------------------------------------------------------------
module tb_adpcm_enc_ctrl;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               enable = 1'b0;
  logic               pcm_valid = 1'b0;
  logic signed [15:0] pcm = '0;
  logic               byte_ready = 1'b0;
  logic               flush = 1'b0;
  logic               core_ack;
  logic [3:0]         core_adpcm;
  logic               pcm_ready, byte_valid, core_req, core_sel_rx;
  logic               busy, err_timeout;
  logic [7:0]         byte_out;
  logic [15:0]        core_pcm, sample_cnt;

  int checks   = 0;
  int failures = 0;

  int   core_mode = 0;
  logic last_req;
  int   ack_cnt;

  always #5 clk = ~clk;

  adpcm_enc_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .pcm_valid   (pcm_valid),
    .pcm_ready   (pcm_ready),
    .pcm         (pcm),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .byte_out    (byte_out),
    .flush       (flush),
    .core_req    (core_req),
    .core_ack    (core_ack),
    .core_pcm    (core_pcm),
    .core_adpcm  (core_adpcm),
    .core_sel_rx (core_sel_rx),
    .busy        (busy),
    .err_timeout (err_timeout),
    .sample_cnt  (sample_cnt)
  );

  // Behavioural codec core
  assign core_adpcm = core_pcm[11:8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_req <= 1'b0;
      core_ack <= 1'b1;
      ack_cnt  <= 0;
    end else begin
      last_req <= core_req;
      if (core_mode == 1) begin
        core_ack <= 1'b1;
      end else if (core_req != last_req) begin
        core_ack <= 1'b0;
        ack_cnt  <= (core_mode == 2) ? 0 : 7;
      end else if (ack_cnt != 0) begin
        ack_cnt <= ack_cnt - 1;
        if (ack_cnt == 1) core_ack <= 1'b1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a sample and return at the negedge following the accepting edge.
  task automatic send_sample(input logic [15:0] v);
    int n = 0;
    pcm       = v;
    pcm_valid = 1'b1;
    while (!pcm_ready && n < 100) begin
      tick();
      n++;
    end
    check_val("accept_wait", 32'(n < 100), 32'd1);
    tick();
    pcm_valid = 1'b0;
    $display("sample 0x%04h accepted at %0t", v, $time);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n < 100), 32'd1);
  endtask

  task automatic wait_byte(output int n);
    n = 0;
    while (!byte_valid && n < 100) begin
      tick();
      n++;
    end
    $display("byte 0x%02h presented after %0d clocks", byte_out, n);
  endtask

  initial begin
    int n;
    int bad;

    // Reset
    rstn   = 1'b0;
    enable = 1'b1;
    repeat (2) tick();
    check_val("rst_pcm_ready",  32'(pcm_ready),   32'd1);
    check_val("rst_busy",       32'(busy),        32'd0);
    check_val("rst_byte_valid", 32'(byte_valid),  32'd0);
    check_val("rst_core_req",   32'(core_req),    32'd0);
    check_val("rst_core_pcm",   32'(core_pcm),    32'd0);
    check_val("rst_byte_out",   32'(byte_out),    32'd0);
    check_val("rst_sample_cnt", 32'(sample_cnt),  32'd0);
    check_val("rst_err",        32'(err_timeout), 32'd0);
    check_val("rst_sel_rx",     32'(core_sel_rx), 32'd0);
    rstn = 1'b1;
    tick();

    // Two samples pack into one byte, second sample latency
    send_sample(16'h0100);
    wait_idle("s1_idle");
    check_val("s1_core_req", 32'(core_req),   32'd1);
    check_val("s1_cnt",      32'(sample_cnt), 32'd1);
    send_sample(16'h0200);
    wait_byte(n);
    check_val("s2_latency",  32'(n),          32'd11);
    check_val("s2_byte",     32'(byte_out),   32'h21);
    check_val("s2_core_req", 32'(core_req),   32'd0);
    check_val("s2_cnt",      32'(sample_cnt), 32'd2);
    check_val("s2_pcm_rdy",  32'(pcm_ready),  32'd0);

    // Stalled consumer: byte held, new samples refused
    pcm       = 16'sh7F00;
    pcm_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!byte_valid || byte_out != 8'h21 || pcm_ready) bad++;
    end
    check_val("out_hold", 32'(bad), 32'd0);
    pcm_valid  = 1'b0;
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check_val("out_rel_valid", 32'(byte_valid), 32'd0);
    check_val("out_rel_ready", 32'(pcm_ready),  32'd1);
    check_val("out_rel_cnt",   32'(sample_cnt), 32'd2);

    // Flush a lone nibble
    send_sample(16'h0300);
    wait_idle("s3_idle");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_valid", 32'(byte_valid), 32'd1);
    check_val("flush_byte",  32'(byte_out),   32'h03);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;

    // Flush with nothing pending emits nothing
    flush = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (byte_valid) bad++;
    end
    flush = 1'b0;
    check_val("flush_empty", 32'(bad), 32'd0);

    // Flush raised while busy is held off, then honoured
    send_sample(16'h0400);
    flush = 1'b1;
    wait_byte(n);
    flush = 1'b0;
    check_val("flush_held_wait", 32'(n < 100), 32'd1);
    check_val("flush_held_byte", 32'(byte_out), 32'h04);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;

    // enable=0 mid-sample: clear, but core_req keeps its level
    send_sample(16'h0500);
    repeat (4) tick();
    check_val("en_mid_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_val("en_busy",     32'(busy),       32'd0);
    check_val("en_core_req", 32'(core_req),   32'd1);
    check_val("en_cnt",      32'(sample_cnt), 32'd0);
    repeat (8) tick();

    // enable=0 discards a pending nibble
    send_sample(16'h0600);
    wait_idle("s6_idle");
    check_val("s6_cnt", 32'(sample_cnt), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    flush = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (byte_valid) bad++;
    end
    flush = 1'b0;
    check_val("en_discard", 32'(bad), 32'd0);

    // Counter wrap
    force dut.sample_cnt_q = 16'hFFFF;
    tick();
    release dut.sample_cnt_q;
    tick();
    check_val("wrap_pre", 32'(sample_cnt), 32'hFFFF);
    send_sample(16'h0700);
    wait_idle("s7_idle");
    check_val("wrap_post", 32'(sample_cnt), 32'd0);

    // Asynchronous reset during WAIT_DONE
    send_sample(16'h0800);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    check_val("arst_core_req", 32'(core_req),    32'd0);
    check_val("arst_busy",     32'(busy),        32'd0);
    check_val("arst_valid",    32'(byte_valid),  32'd0);
    check_val("arst_cnt",      32'(sample_cnt),  32'd0);
    check_val("arst_core_pcm", 32'(core_pcm),    32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    send_sample(16'h0900);
    wait_idle("s9_idle");
    send_sample(16'h0A00);
    wait_byte(n);
    check_val("arst_after_byte", 32'(byte_out),   32'hA9);
    check_val("arst_after_cnt",  32'(sample_cnt), 32'd2);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;

    // Core never starts: ERR after 4 WAIT_BUSY samples
    core_mode = 1;
    send_sample(16'h0B00);
    n = 0;
    while (!err_timeout && n < 50) begin
      tick();
      n++;
    end
    check_val("err_busy_latency", 32'(n), 32'd5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!err_timeout || pcm_ready || byte_valid || !busy) bad++;
    end
    check_val("err_sticky",   32'(bad),      32'd0);
    check_val("err_core_req", 32'(core_req), 32'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_val("err_clr",       32'(err_timeout), 32'd0);
    check_val("err_clr_ready", 32'(pcm_ready),   32'd1);

    // Core never finishes: ERR after 16 WAIT_DONE samples
    core_mode = 2;
    send_sample(16'h0C00);
    n = 0;
    while (!err_timeout && n < 50) begin
      tick();
      n++;
    end
    check_val("err_done_latency", 32'(n), 32'd19);
    enable    = 1'b0;
    core_mode = 1;
    tick();
    enable    = 1'b1;
    core_mode = 0;
    tick();
    check_val("err2_clr", 32'(err_timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
